// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Operation codes and shared constants for the execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int unsigned C_OP_W = 5;

    // Operation[BRANCH_BIT] set marks a branch compare; Out is forced to zero.
    localparam int unsigned BRANCH_BIT = 4;

    localparam logic [C_OP_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [C_OP_W-1:0] OP_SUB   = 5'b00001;
    localparam logic [C_OP_W-1:0] OP_SLL   = 5'b00010;
    localparam logic [C_OP_W-1:0] OP_SLT   = 5'b00011;
    localparam logic [C_OP_W-1:0] OP_SLTU  = 5'b00100;
    localparam logic [C_OP_W-1:0] OP_XOR   = 5'b00101;
    localparam logic [C_OP_W-1:0] OP_SRL   = 5'b00110;
    localparam logic [C_OP_W-1:0] OP_SRA   = 5'b00111;
    localparam logic [C_OP_W-1:0] OP_OR    = 5'b01000;
    localparam logic [C_OP_W-1:0] OP_AND   = 5'b01001;
    localparam logic [C_OP_W-1:0] OP_PASSB = 5'b01010;
    localparam logic [C_OP_W-1:0] OP_PASSA = 5'b01011;

    localparam logic [C_OP_W-1:0] OP_BEQ   = 5'b10000;
    localparam logic [C_OP_W-1:0] OP_BNE   = 5'b10001;
    localparam logic [C_OP_W-1:0] OP_BLT   = 5'b10100;
    localparam logic [C_OP_W-1:0] OP_BGE   = 5'b10101;
    localparam logic [C_OP_W-1:0] OP_BLTU  = 5'b10110;
    localparam logic [C_OP_W-1:0] OP_BGEU  = 5'b10111;

endpackage
`default_nettype wire

// File: rtl/exec_cmp.sv
`default_nettype none
// ============================================================================
// Module      : exec_cmp
// Description : Combinational comparator shared by set-less-than and branches.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_cmp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             eq,
    output logic             lt_s,
    output logic             lt_u
);

    assign eq   = (A == B);
    assign lt_s = ($signed(A) < $signed(B));
    assign lt_u = (A < B);

endmodule
`default_nettype wire

// File: rtl/exec.sv
`default_nettype none
// ============================================================================
// Module      : exec
// Description : Execute-stage ALU with registered result and branch flag.
// Revision    : 1.0 - initial release
// ============================================================================
module exec
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  Operand1,
    input  logic [WIDTH-1:0]  Operand2,
    input  logic [4:0]        Operation,
    output logic [WIDTH-1:0]  Out,
    output logic              bcond
);

    logic [WIDTH-1:0] w_out;
    logic             w_bcond;
    logic [4:0]       w_shamt;
    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [WIDTH-1:0] r_out;
    logic             r_bcond;

    assign w_shamt = Operand2[4:0];

    exec_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .A    (Operand1),
        .B    (Operand2),
        .eq   (w_eq),
        .lt_s (w_lt_s),
        .lt_u (w_lt_u)
    );

    // Unknown codes (including X/Z) fall to the defaults so nothing undefined is registered.
    always_comb begin
        w_out   = '0;
        w_bcond = 1'b0;
        if (Operation[BRANCH_BIT] == 1'b1) begin
            case (Operation)
                OP_BEQ:  w_bcond = w_eq;
                OP_BNE:  w_bcond = ~w_eq;
                OP_BLT:  w_bcond = w_lt_s;
                OP_BGE:  w_bcond = ~w_lt_s;
                OP_BLTU: w_bcond = w_lt_u;
                OP_BGEU: w_bcond = ~w_lt_u;
                default: w_bcond = 1'b0;
            endcase
        end else begin
            case (Operation)
                OP_ADD:   w_out = Operand1 + Operand2;
                OP_SUB:   w_out = Operand1 - Operand2;
                OP_SLL:   w_out = Operand1 << w_shamt;
                OP_SLT:   w_out = {{(WIDTH-1){1'b0}}, w_lt_s};
                OP_SLTU:  w_out = {{(WIDTH-1){1'b0}}, w_lt_u};
                OP_XOR:   w_out = Operand1 ^ Operand2;
                OP_SRL:   w_out = Operand1 >> w_shamt;
                OP_SRA:   w_out = $unsigned($signed(Operand1) >>> w_shamt);
                OP_OR:    w_out = Operand1 | Operand2;
                OP_AND:   w_out = Operand1 & Operand2;
                OP_PASSB: w_out = Operand2;
                OP_PASSA: w_out = Operand1;
                default:  w_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_bcond <= 1'b0;
        end else begin
            r_out   <= w_out;
            r_bcond <= w_bcond;
        end
    end

    assign Out   = r_out;
    assign bcond = r_bcond;

endmodule
`default_nettype wire

// File: tb/tb_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec
// Description : Directed self-checking bench for the execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [4:0]  Operation;
    logic [31:0] Out;
    logic        bcond;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    exec #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Operation (Operation),
        .Out       (Out),
        .bcond     (bcond)
    );

    task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        Operation = op;
        Operand1  = a;
        Operand2  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(OP_ADD, 32'd5, 32'd7);
        step(OP_ADD, 32'd5, 32'd7);
        total_cnt++;
        if (Out !== 32'h0) $display("FAIL reset_out: got %h expected %h", Out, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL reset_bcond: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (Out !== 32'd12) $display("FAIL release_add: got %h expected %h", Out, 32'd12);
        else pass_cnt++;
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL release_bcond: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
    endtask

    task automatic test_arith();
        Operation = OP_ADD; Operand1 = 32'hFFFF_FFFF; Operand2 = 32'd1;
        #2;
        total_cnt++;
        if (Out !== 32'd12) $display("FAIL add_latency: got %h expected %h", Out, 32'd12);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (Out !== 32'h0) $display("FAIL add_wrap: got %h expected %h", Out, 32'h0);
        else pass_cnt++;
        step(OP_SUB, 32'h0, 32'd1);
        total_cnt++;
        if (Out !== 32'hFFFF_FFFF) $display("FAIL sub_wrap: got %h expected %h", Out, 32'hFFFF_FFFF);
        else pass_cnt++;
        step(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
        total_cnt++;
        if (Out !== 32'h5555_5555) $display("FAIL xor: got %h expected %h", Out, 32'h5555_5555);
        else pass_cnt++;
        step(OP_OR, 32'h1200_0034, 32'h0056_7800);
        total_cnt++;
        if (Out !== 32'h1256_7834) $display("FAIL or: got %h expected %h", Out, 32'h1256_7834);
        else pass_cnt++;
        step(OP_PASSB, 32'h1111_1111, 32'hABCD_E000);
        total_cnt++;
        if (Out !== 32'hABCD_E000) $display("FAIL passb: got %h expected %h", Out, 32'hABCD_E000);
        else pass_cnt++;
        step(OP_PASSA, 32'h1111_1111, 32'hABCD_E000);
        total_cnt++;
        if (Out !== 32'h1111_1111) $display("FAIL passa: got %h expected %h", Out, 32'h1111_1111);
        else pass_cnt++;
    endtask

    task automatic test_shifts();
        step(OP_SRA, 32'h8000_0000, 32'd4);
        total_cnt++;
        if (Out !== 32'hF800_0000) $display("FAIL sra: got %h expected %h", Out, 32'hF800_0000);
        else pass_cnt++;
        step(OP_SRL, 32'h8000_0000, 32'd4);
        total_cnt++;
        if (Out !== 32'h0800_0000) $display("FAIL srl: got %h expected %h", Out, 32'h0800_0000);
        else pass_cnt++;
        step(OP_SLL, 32'h1, 32'd33);
        total_cnt++;
        if (Out !== 32'h0000_0002) $display("FAIL sll_33: got %h expected %h", Out, 32'h0000_0002);
        else pass_cnt++;
        step(OP_SRA, 32'h8765_4321, 32'd0);
        total_cnt++;
        if (Out !== 32'h8765_4321) $display("FAIL sra_by0: got %h expected %h", Out, 32'h8765_4321);
        else pass_cnt++;
        step(OP_SRA, 32'h4000_0000, 32'd30);
        total_cnt++;
        if (Out !== 32'h0000_0001) $display("FAIL sra_pos: got %h expected %h", Out, 32'h0000_0001);
        else pass_cnt++;
    endtask

    task automatic test_compare();
        step(OP_SLT, 32'h8000_0000, 32'd1);
        total_cnt++;
        if (Out !== 32'd1) $display("FAIL slt: got %h expected %h", Out, 32'd1);
        else pass_cnt++;
        step(OP_SLTU, 32'h8000_0000, 32'd1);
        total_cnt++;
        if (Out !== 32'd0) $display("FAIL sltu: got %h expected %h", Out, 32'd0);
        else pass_cnt++;
        step(OP_BLT, 32'h8000_0000, 32'd1);
        total_cnt++;
        if (bcond !== 1'b1) $display("FAIL blt_bcond: got %b expected %b", bcond, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (Out !== 32'h0) $display("FAIL blt_out: got %h expected %h", Out, 32'h0);
        else pass_cnt++;
        step(OP_BGEU, 32'h8000_0000, 32'd1);
        total_cnt++;
        if (bcond !== 1'b1) $display("FAIL bgeu: got %b expected %b", bcond, 1'b1);
        else pass_cnt++;
        step(OP_BLTU, 32'h8000_0000, 32'd1);
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL bltu: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
        step(OP_BGE, 32'h8000_0000, 32'd1);
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL bge: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
        step(OP_BGE, 32'd7, 32'd7);
        total_cnt++;
        if (bcond !== 1'b1) $display("FAIL bge_equal: got %b expected %b", bcond, 1'b1);
        else pass_cnt++;
    endtask

    task automatic test_equality();
        step(OP_BEQ, 32'h1234, 32'h1234);
        total_cnt++;
        if (bcond !== 1'b1) $display("FAIL beq_eq: got %b expected %b", bcond, 1'b1);
        else pass_cnt++;
        step(OP_BNE, 32'h1234, 32'h1234);
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL bne_eq: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
        step(OP_BEQ, 32'h1234, 32'h1235);
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL beq_ne: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
        step(OP_BNE, 32'h1234, 32'h1235);
        total_cnt++;
        if (bcond !== 1'b1) $display("FAIL bne_ne: got %b expected %b", bcond, 1'b1);
        else pass_cnt++;
    endtask

    task automatic test_illegal_back_to_back();
        step(OP_PASSA, 32'hDEAD_BEEF, 32'h1);
        step(5'b11111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        total_cnt++;
        if (Out !== 32'h0) $display("FAIL illegal_out: got %h expected %h", Out, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL illegal_bcond: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
        step(5'b01100, 32'hDEAD_BEEF, 32'h5);
        total_cnt++;
        if (Out !== 32'h0) $display("FAIL undef_alu_out: got %h expected %h", Out, 32'h0);
        else pass_cnt++;
        step(OP_BEQ, 32'h0, 32'h0);
        step(5'bxxxxx, 32'h0, 32'h0);
        total_cnt++;
        if (Out !== 32'h0) $display("FAIL x_op_out: got %h expected %h", Out, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL x_op_bcond: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
        step(OP_BEQ, 32'h55, 32'h55);
        step(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        total_cnt++;
        if (Out !== 32'hF000_F000) $display("FAIL and_b2b: got %h expected %h", Out, 32'hF000_F000);
        else pass_cnt++;
        total_cnt++;
        if (bcond !== 1'b0) $display("FAIL and_stale_bcond: got %b expected %b", bcond, 1'b0);
        else pass_cnt++;
    endtask

    initial begin
        rst_n     = 1'b0;
        Operation = OP_ADD;
        Operand1  = 32'h0;
        Operand2  = 32'h0;
        test_reset();
        test_arith();
        test_shifts();
        test_compare();
        test_equality();
        test_illegal_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
